multicycle_addsub: RTL

- Parametrised, chunk-sequential adder/subtractor. Successor to the fixed 8/32-bit ripple adders.
- Processes CHUNK bits per clock across a WIDTH-bit operand pair, trading latency for a short carry chain.
- Sits between an operand producer and a result consumer using valid/ready handshakes on both sides.
- Adds subtract mode, carry-out and signed overflow flags.

---
 rtl/multicycle_addsub.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/multicycle_addsub.sv
// Chunk-sequential WIDTH-bit adder/subtractor: CHUNK bits per clock with the
// carry held in a register between chunks, valid/ready handshake on both sides.
module multicycle_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
        $error("multicycle_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [31:0]        base_s;
    logic [CHUNK-1:0]   a_chunk_s;
    logic [CHUNK-1:0]   b_chunk_s;
    logic [CHUNK:0]     chunk_sum_s;
    logic [WIDTH-1:0]   chunk_mask_s;

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            idx_q       <= {IDX_W{1'b0}};
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state logic and the single-chunk adder slice.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        idx_d        = idx_q;
        out_valid_d  = out_valid_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;

        base_s       = 32'(idx_q) * 32'(CHUNK);
        a_chunk_s    = CHUNK'(a_q >> base_s);
        b_chunk_s    = CHUNK'(b_q >> base_s);
        chunk_sum_s  = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + (CHUNK+1)'(carry_q);
        chunk_mask_s = WIDTH'({CHUNK{1'b1}}) << base_s;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~chunk_mask_s) | (WIDTH'(chunk_sum_s[CHUNK-1:0]) << base_s);
                carry_d = chunk_sum_s[CHUNK];
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    // The last chunk holds the MSB, so both flags resolve here.
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cout_d      = chunk_sum_s[CHUNK];
                    ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (chunk_sum_s[CHUNK-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
